// File: rtl/dvd_bounce_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dvd_pkg
//  Purpose  : Shared types and constants for the bouncing-sprite controller:
//             scheduler state encoding and the six-entry colour palette.
//  Revision : 1.0  initial release
// ============================================================================
package dvd_pkg;

  // Update scheduler states; every non-idle state lasts exactly one cycle
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_MOVE_X = 2'd1,
    S_MOVE_Y = 2'd2,
    S_COLOR  = 2'd3
  } state_t;

  localparam int PALETTE_LEN = 6;

  // Pixel format is {R1,G1,B1,R0,G0,B0}; both bits of a channel set = full on
  localparam logic [5:0] C_RED     = 6'b100_100;
  localparam logic [5:0] C_YELLOW  = 6'b110_110;
  localparam logic [5:0] C_GREEN   = 6'b010_010;
  localparam logic [5:0] C_CYAN    = 6'b011_011;
  localparam logic [5:0] C_BLUE    = 6'b001_001;
  localparam logic [5:0] C_MAGENTA = 6'b101_101;

  // Entry 0 sits in the low bits, so PALETTE[idx] selects colour idx
  localparam logic [PALETTE_LEN-1:0][5:0] PALETTE = {
    C_MAGENTA, C_BLUE, C_CYAN, C_GREEN, C_YELLOW, C_RED
  };

  // Advance the colour index, wrapping after the last palette entry
  function automatic logic [2:0] next_color_idx(input logic [2:0] idx);
    if (idx == 3'(PALETTE_LEN - 1)) begin
      return 3'd0;
    end
    return idx + 3'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dvd_bounce_ctrl_axis_step.sv
`default_nettype none
// ============================================================================
//  Module   : dvd_axis_step
//  Purpose  : Combinational one-step move along a single axis with reflection
//             at 0 and at LIMIT. A bounce reverses direction and steps one
//             position inward in the same update, so the sprite never rests
//             on an edge. The caller registers the results.
//  Revision : 1.0  initial release
// ============================================================================
module dvd_axis_step
  import dvd_pkg::*;
#(
  parameter int WIDTH = 6,
  parameter int LIMIT = 39
) (
  input  logic [WIDTH-1:0] pos,
  input  logic             dir,
  output logic [WIDTH-1:0] next_pos,
  output logic             next_dir,
  output logic             hit
);

  localparam logic [WIDTH-1:0] C_LIMIT = WIDTH'(LIMIT);

  // Reflect at the far edge when increasing, at zero when decreasing
  always_comb begin
    next_pos = pos;
    next_dir = dir;
    hit      = 1'b0;
    if (dir && (pos == C_LIMIT)) begin
      next_dir = 1'b0;
      next_pos = pos - 1'b1;
      hit      = 1'b1;
    end else if (!dir && (pos == '0)) begin
      next_dir = 1'b1;
      next_pos = WIDTH'(1);
      hit      = 1'b1;
    end else if (dir) begin
      next_pos = pos + 1'b1;
    end else begin
      next_pos = pos - 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dvd_bounce_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : dvd_bounce_ctrl
//  Purpose  : Per-frame scheduler for the bouncing sprite. Every FRAME_DIV
//             rising edges of vsync it moves X, then Y, then updates the
//             colour, all inside vertical blanking. Also renders the sprite
//             into a registered 6-bit RGB output.
//  Options  : DVD_CORNER_FLASH_EN - a corner hit turns the sprite white for
//             FLASH_FRAMES frames.
//  Revision : 1.0  initial release
// ============================================================================
module dvd_bounce_ctrl
  import dvd_pkg::*;
#(
  parameter int H_DISPLAY    = 40,
  parameter int V_DISPLAY    = 480,
  parameter int BOX_W        = 1,
  parameter int BOX_H        = 12,
  parameter int INIT_X       = 20,
  parameter int INIT_Y       = 240,
  parameter int FRAME_DIV    = 2
`ifdef DVD_CORNER_FLASH_EN
  ,
  parameter int FLASH_FRAMES = 30
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [5:0] hpos,
  input  logic [9:0] vpos,
  input  logic       display_on,
  input  logic       vsync,
  output logic [5:0] rgb,
  output logic [5:0] box_x,
  output logic [9:0] box_y,
  output logic       corner_hit,
  output logic [7:0] bounce_cnt
);

  localparam int         FC_W      = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [FC_W-1:0] C_FC_LAST = FC_W'(FRAME_DIV - 1);

  state_t          r_state;
  logic            r_vsync_d;
  logic [FC_W-1:0] r_frame_cnt;
  logic [5:0]      r_box_x;
  logic [9:0]      r_box_y;
  logic            r_dx;
  logic            r_dy;
  logic            r_hx;
  logic            r_hy;
  logic [2:0]      r_color_idx;
  logic [7:0]      r_bounce_cnt;
  logic            r_corner_hit;
  logic [5:0]      r_rgb;

  logic            w_tick;
  logic [5:0]      w_x_next;
  logic            w_dx_next;
  logic            w_hx;
  logic [9:0]      w_y_next;
  logic            w_dy_next;
  logic            w_hy;
  logic            w_inside;
  logic [5:0]      w_color;

  assign w_tick = vsync & ~r_vsync_d;

  dvd_axis_step #(
    .WIDTH (6),
    .LIMIT (H_DISPLAY - BOX_W)
  ) u_axis_x (
    .pos      (r_box_x),
    .dir      (r_dx),
    .next_pos (w_x_next),
    .next_dir (w_dx_next),
    .hit      (w_hx)
  );

  dvd_axis_step #(
    .WIDTH (10),
    .LIMIT (V_DISPLAY - BOX_H)
  ) u_axis_y (
    .pos      (r_box_y),
    .dir      (r_dy),
    .next_pos (w_y_next),
    .next_dir (w_dy_next),
    .hit      (w_hy)
  );

  // Frame divider plus the X -> Y -> colour update sequence
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_vsync_d    <= 1'b0;
      r_frame_cnt  <= '0;
      r_box_x      <= 6'(INIT_X);
      r_box_y      <= 10'(INIT_Y);
      r_dx         <= 1'b1;
      r_dy         <= 1'b1;
      r_hx         <= 1'b0;
      r_hy         <= 1'b0;
      r_color_idx  <= 3'd0;
      r_bounce_cnt <= 8'd0;
      r_corner_hit <= 1'b0;
    end else begin
      r_vsync_d    <= vsync;
      r_corner_hit <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // Ticks are only honoured here; the counter holds while run is low
          if (w_tick && run) begin
            if (r_frame_cnt == C_FC_LAST) begin
              r_frame_cnt <= '0;
              r_state     <= S_MOVE_X;
            end else begin
              r_frame_cnt <= r_frame_cnt + 1'b1;
            end
          end
        end
        S_MOVE_X: begin
          r_box_x <= w_x_next;
          r_dx    <= w_dx_next;
          r_hx    <= w_hx;
          r_state <= S_MOVE_Y;
        end
        S_MOVE_Y: begin
          r_box_y <= w_y_next;
          r_dy    <= w_dy_next;
          r_hy    <= w_hy;
          r_state <= S_COLOR;
        end
        S_COLOR: begin
          // A corner counts as a single bounce
          if (r_hx || r_hy) begin
            r_color_idx  <= next_color_idx(r_color_idx);
            r_bounce_cnt <= r_bounce_cnt + 8'd1;
          end
          r_corner_hit <= r_hx & r_hy;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef DVD_CORNER_FLASH_EN
  localparam int FL_W = $clog2(FLASH_FRAMES + 1);

  logic [FL_W-1:0] r_flash_cnt;
  logic            w_corner_load;

  assign w_corner_load = (r_state == S_COLOR) & r_hx & r_hy;

  // Flash timer: reloaded by each corner hit, counts frames down to zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flash_cnt <= '0;
    end else if (w_corner_load) begin
      r_flash_cnt <= FL_W'(FLASH_FRAMES);
    end else if (w_tick && (r_flash_cnt != '0)) begin
      r_flash_cnt <= r_flash_cnt - 1'b1;
    end
  end

  assign w_color = (r_flash_cnt != '0) ? 6'h3F : PALETTE[r_color_idx];
`else
  assign w_color = PALETTE[r_color_idx];
`endif

  // Extra MSB keeps box_x+BOX_W and box_y+BOX_H from wrapping
  assign w_inside = display_on
                  & ({1'b0, hpos} >= {1'b0, r_box_x})
                  & ({1'b0, hpos} <  ({1'b0, r_box_x} + 7'(BOX_W)))
                  & ({1'b0, vpos} >= {1'b0, r_box_y})
                  & ({1'b0, vpos} <  ({1'b0, r_box_y} + 11'(BOX_H)));

  // Registered pixel output, one clock behind the beam position
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rgb <= 6'd0;
    end else begin
      r_rgb <= w_inside ? w_color : 6'd0;
    end
  end

  assign rgb        = r_rgb;
  assign box_x      = r_box_x;
  assign box_y      = r_box_y;
  assign corner_hit = r_corner_hit;
  assign bounce_cnt = r_bounce_cnt;

endmodule
`default_nettype wire

// File: tb/tb_dvd_bounce_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dvd_bounce_ctrl
//  Purpose  : Self-checking bench for dvd_bounce_ctrl. Instance A uses the
//             default geometry; instance B uses a 3-column field starting
//             near the bottom edge so a corner and counter wrap occur quickly.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dvd_bounce_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run_a, run_b;
  logic       vsync_a, vsync_b;
  logic       display_on;
  logic [5:0] hpos;
  logic [9:0] vpos;

  logic [5:0] rgb_a, rgb_b;
  logic [5:0] box_x_a, box_x_b;
  logic [9:0] box_y_a, box_y_b;
  logic       corner_hit_a, corner_hit_b;
  logic [7:0] bounce_cnt_a, bounce_cnt_b;

  always #5 clk = ~clk;

  dvd_bounce_ctrl u_dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run_a),
    .hpos       (hpos),
    .vpos       (vpos),
    .display_on (display_on),
    .vsync      (vsync_a),
    .rgb        (rgb_a),
    .box_x      (box_x_a),
    .box_y      (box_y_a),
    .corner_hit (corner_hit_a),
    .bounce_cnt (bounce_cnt_a)
  );

  dvd_bounce_ctrl #(
    .H_DISPLAY (3),
    .INIT_X    (2),
    .INIT_Y    (466),
    .FRAME_DIV (1)
  ) u_dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run_b),
    .hpos       (hpos),
    .vpos       (vpos),
    .display_on (display_on),
    .vsync      (vsync_b),
    .rgb        (rgb_b),
    .box_x      (box_x_b),
    .box_y      (box_y_b),
    .corner_hit (corner_hit_b),
    .bounce_cnt (bounce_cnt_b)
  );

  // ---------------------------------------------------------------- model
  int lim_x [2] = '{39, 2};
  int lim_y [2] = '{468, 468};
  int init_x[2] = '{20, 2};
  int init_y[2] = '{240, 466};
  int fdiv  [2] = '{2, 1};

  int mx[2], mdx[2], my[2], mdy[2], midx[2], mb[2], mfc[2];
  int mcorner[2], mhit[2], mflash[2];

  int n_vec = 0;
  int n_mis = 0;
  int cc[2];

  typedef struct {
    int inst;
    int x;
    int y;
    int b;
    int hit;
    int rgb;
  } exp_t;
  exp_t sbq[$];

  // Corner pulse monitor: counts high cycles of corner_hit per instance
  always @(negedge clk) begin
    if (!rst_n) begin
      cc[0] = 0;
      cc[1] = 0;
    end else begin
      if (corner_hit_a) cc[0] = cc[0] + 1;
      if (corner_hit_b) cc[1] = cc[1] + 1;
    end
  end

  function automatic logic [5:0] pal(input int i);
    case (i)
      0: return 6'h24;
      1: return 6'h36;
      2: return 6'h12;
      3: return 6'h1B;
      4: return 6'h09;
      default: return 6'h2D;
    endcase
  endfunction

  task automatic model_reset(input int i);
    mx[i] = init_x[i]; my[i] = init_y[i];
    mdx[i] = 1; mdy[i] = 1;
    midx[i] = 0; mb[i] = 0; mfc[i] = 0;
    mcorner[i] = 0; mhit[i] = 0; mflash[i] = 0;
  endtask

  task automatic model_axis(input int pos, input int dir, input int lim,
                            output int npos, output int ndir, output int hit);
    if (dir == 1 && pos == lim) begin
      npos = pos - 1; ndir = 0; hit = 1;
    end else if (dir == 0 && pos == 0) begin
      npos = 1; ndir = 1; hit = 1;
    end else begin
      npos = (dir == 1) ? pos + 1 : pos - 1; ndir = dir; hit = 0;
    end
  endtask

  task automatic model_tick(input int i, input logic r);
    int nx, ndx, hx, ny, ndy, hy;
    mhit[i] = 0;
    if (mflash[i] > 0) mflash[i] = mflash[i] - 1;
    if (r) begin
      mfc[i] = mfc[i] + 1;
      if (mfc[i] == fdiv[i]) begin
        mfc[i] = 0;
        model_axis(mx[i], mdx[i], lim_x[i], nx, ndx, hx);
        model_axis(my[i], mdy[i], lim_y[i], ny, ndy, hy);
        mx[i] = nx; mdx[i] = ndx; my[i] = ny; mdy[i] = ndy;
        if (hx == 1 || hy == 1) begin
          midx[i] = (midx[i] + 1) % 6;
          mb[i]   = (mb[i] + 1) % 256;
        end
        if (hx == 1 && hy == 1) begin
          mhit[i] = 1;
          mcorner[i] = mcorner[i] + 1;
          mflash[i] = 30;
        end
      end
    end
  endtask

  function automatic int exp_pixel(input int i, input int h, input int v, input int de);
    if (de == 1 && h >= mx[i] && h < mx[i] + 1 && v >= my[i] && v < my[i] + 12) begin
`ifdef DVD_CORNER_FLASH_EN
      if (mflash[i] > 0) return 'h3F;
`endif
      return int'(pal(midx[i]));
    end
    return 0;
  endfunction

  // ---------------------------------------------------------------- checks
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One vsync pulse on instance i; the update must be complete 3 clocks after the tick edge
  task automatic pulse(input int i);
    exp_t e;
    @(negedge clk);
    if (i == 0) vsync_a = 1'b1; else vsync_b = 1'b1;
    model_tick(i, (i == 0) ? run_a : run_b);
    e.inst = i; e.x = mx[i]; e.y = my[i]; e.b = mb[i]; e.hit = mhit[i]; e.rgb = 0;
    sbq.push_back(e);
    repeat (4) @(posedge clk);
    #1;
    e = sbq.pop_front();
    if (e.inst == 0) begin
      check("box_x_a", box_x_a, e.x);
      check("box_y_a", box_y_a, e.y);
      check("bounce_cnt_a", bounce_cnt_a, e.b);
      check("corner_hit_a", corner_hit_a, e.hit);
    end else begin
      check("box_x_b", box_x_b, e.x);
      check("box_y_b", box_y_b, e.y);
      check("bounce_cnt_b", bounce_cnt_b, e.b);
      check("corner_hit_b", corner_hit_b, e.hit);
    end
    @(negedge clk);
    if (i == 0) vsync_a = 1'b0; else vsync_b = 1'b0;
    repeat (2) @(negedge clk);
    check((i == 0) ? "corner_cycles_a" : "corner_cycles_b", cc[i], mcorner[i]);
  endtask

  // Drive a beam position and compare the registered pixel one clock later
  task automatic probe(input int i, input int h, input int v, input int de);
    exp_t e;
    @(negedge clk);
    hpos = 6'(h); vpos = 10'(v); display_on = (de == 1);
    e.inst = i; e.x = 0; e.y = 0; e.b = 0; e.hit = 0; e.rgb = exp_pixel(i, h, v, de);
    sbq.push_back(e);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    if (e.inst == 0) check("rgb_a", rgb_a, e.rgb);
    else             check("rgb_b", rgb_b, e.rgb);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    rst_n = 1'b0; run_a = 1'b0; run_b = 1'b0;
    vsync_a = 1'b0; vsync_b = 1'b0;
    display_on = 1'b0; hpos = '0; vpos = '0;
    model_reset(0); model_reset(1);

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_box_x", box_x_a, 20);
    check("rst_box_y", box_y_a, 240);
    check("rst_rgb", rgb_a, 0);
    check("rst_bounce", bounce_cnt_a, 0);
    check("rst_corner", corner_hit_a, 0);

    // Movement: four ticks with FRAME_DIV=2 give two steps
    run_a = 1'b1;
    for (int k = 0; k < 4; k++) pulse(0);
    check("move_x", box_x_a, 22);
    check("move_y", box_y_a, 242);

    // Asynchronous reset while the sequence is in S_MOVE_Y
    pulse(0);
    @(negedge clk);
    vsync_a = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("inflight_x", box_x_a, 23);
    rst_n = 1'b0;
    #1;
    check("midrst_box_x", box_x_a, 20);
    check("midrst_box_y", box_y_a, 240);
    check("midrst_rgb", rgb_a, 0);
    check("midrst_bounce", bounce_cnt_a, 0);
    vsync_a = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset(0); model_reset(1);

    // Pause: position and frame divider frozen across ten ticks
    run_a = 1'b0;
    for (int k = 0; k < 10; k++) pulse(0);
    check("pause_x", box_x_a, 20);
    check("pause_y", box_y_a, 240);

    // Twenty steps: the 20th reflects at column 39
    run_a = 1'b1;
    for (int k = 0; k < 40; k++) pulse(0);
    check("xb_box_x", box_x_a, 38);
    check("xb_box_y", box_y_a, 260);
    check("xb_bounce", bounce_cnt_a, 1);
    check("xb_corner_cycles", cc[0], 0);

    // Pixel path around sprite (38,260), colour index 1
    probe(0, 38, 265, 1);
    check("pix_on", rgb_a, 6'h36);
    probe(0, 39, 265, 1);
    probe(0, 37, 265, 1);
    probe(0, 38, 260, 1);
    probe(0, 38, 271, 1);
    probe(0, 38, 272, 1);
    probe(0, 38, 259, 1);
    probe(0, 38, 265, 0);

    // Instance B: corner on step 3, then long run for colour and counter wrap
    run_b = 1'b1;
    for (int k = 0; k < 3; k++) pulse(1);
    check("corner_x", box_x_b, 1);
    check("corner_y", box_y_b, 467);
    check("corner_bounce", bounce_cnt_b, 2);
    check("corner_cycles", cc[1], 1);
    for (int k = 0; k < 530; k++) begin
      pulse(1);
      probe(1, mx[1], my[1] + 11, 1);
    end
    probe(1, mx[1] + 1, my[1], 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
